arm_block_transfer_seq: RTL and testbench
=========================================

// Module: arm_block_transfer_seq
// PURPOSE
//  Executes ARM LDM/STM: consumes the decoded block fields (P,U,S,W,reg_list,Rn) from the decoder's
//  decoded_word_t and sequences one word transfer per listed register. Sits between the control unit,
//  the register file and the memory bus port. Computes addresses and drives register-file reads/writes.
//  Handles base writeback, the empty-list case and the S-bit user-bank/SPSR rules.
// PARAMETERS
//  ADDR_W    32  address/data width (word_t)
//  NUM_REGS  16  register-list width; ARM state is fixed at 16
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst_n          in   1       asynchronous, active-low reset
//  start          in   1       start a transfer; accepted only when start_ready=1
//  start_ready    out  1       high in IDLE only
//  is_load        in   1       1=LDM, 0=STM
//  P,U,S,W        in   1 each  decoded block flags (pre, up, PSR/user, writeback)
//  reg_list       in   16      decoded reg_list
//  rn_idx         in   4       base register index
//  base_val       in   32      Rn value at start
//  mem_req        out  1       memory request, held until mem_ack
//  mem_we         out  1       1=store
//  mem_addr       out  32      word address, bits[1:0]=0
//  mem_wdata      out  32      store data
//  mem_ack        in   1       transfer complete; mem_rdata valid this cycle on loads
//  mem_rdata      in   32      load data
//  rf_rd_idx      out  4       register-file read index (STM data)
//  rf_rd_data     in   32      combinational read data
//  rf_wr_en       out  1       register-file write strobe
//  rf_wr_idx      out  4       register-file write index
//  rf_wr_data     out  32      register-file write data
//  rf_user_bank   out  1       force user-bank register access
//  spsr_restore   out  1       1-cycle pulse: CPSR<=SPSR (LDM with S and R15 in list)
//  done           out  1       1-cycle pulse when the instruction retires
// BEHAVIOUR
//  Reset: state=IDLE; start_ready=1; all other outputs 0.
//  States: IDLE -> SETUP (on start) -> XFER -> (mem_ack, regs left) XFER | (mem_ack, last) WB -> IDLE.
//   done pulses in WB. spsr_restore pulses in WB. No other transitions.
//  SETUP (1 cycle): latch inputs; n=popcount(reg_list). Empty list: treat as {R15}, n_eff=16 for address math.
//   Start addr (lowest reg at lowest address): IA=base, IB=base+4, DA=base-4*n_eff+4, DB=base-4*n_eff.
//   new_base = U ? base+4*n_eff : base-4*n_eff. All mod 2^32; base[1:0] ignored (forced 0).
//  XFER: current reg = lowest set bit of the remaining list; mem_req=1, mem_we=!is_load, mem_addr=cur_addr.
//   mem_wdata = rf_rd_data(rf_rd_idx=cur), except the STM case below. Outputs stable while mem_req && !mem_ack.
//   On mem_ack: clear the bit, cur_addr += 4; if load then rf_wr_en=1, idx=cur, data=mem_rdata in that same cycle.
//  Minimum latency: 1 + n + 1 cycles, with mem_ack in the same cycle as each mem_req.
//  Writeback (W=1), in WB: rf_wr_en, idx=rn_idx, data=new_base. Suppressed when is_load && Rn in list (loaded value wins).
//  STM with Rn in list and W=1: Rn lowest in list -> store original base; otherwise -> store new_base.
//  STM storing R15 stores rf_rd_data as supplied; the register file provides PC+12.
//  S=1: rf_user_bank=1 throughout XFER when STM, or LDM without R15. LDM with R15: rf_user_bank=0, spsr_restore in WB.
//   W=1 with rf_user_bank is unpredictable; writeback is still performed to the current bank.
//  start while busy: ignored. rst_n low mid-transfer: immediate return to IDLE, mem_req drops asynchronously, no writeback.
// STRUCTURE
//  cpu_types_pkg: block_mode_t enum {IA,IB,DA,DB} and constant WORD_BYTES=4.
//  Sub-module reg_list_scanner: combinational lowest-set-bit index plus popcount on 16 bits.
//  Remaining-list register, addr register, latched flags, and a 3-bit state enum are local.
// TESTING
//  LDMIA base=0x100, list=0x000E, W=1, ack immediate -> loads R1..R3 from 0x100/104/108; R0(Rn)=0x10C; done at cycle 5.
//  STMDB base=0x3000_0200, list=0x4010 (R4,LR), W=1 -> stores to 0x1F8,0x1FC; Rn=0x3000_01F8.
//  Empty list, LDMIA base=0x200, W=1 -> single load of R15 from 0x200; Rn=0x240.
//  STMIA Rn=R2, list=0x0006, W=1: R1 is lowest -> stores R1, then new_base for R2. Repeat with list=0x0004 -> stores the original base.
//  LDMIB S=1 with R15 in list, mem_ack delayed 3 cycles each -> mem outputs held stable; spsr_restore pulses with done; no user bank.
//  rst_n asserted during the 2nd transfer -> outputs 0 the same cycle; no writeback; start accepted after release.

Source files
------------

// File: rtl/arm_block_transfer_seq_pkg.sv
// arm_block_transfer_seq_pkg: shared types for the LDM/STM block-transfer sequencer.
package arm_block_transfer_seq_pkg;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {DA = 2'b00, IA = 2'b01, DB = 2'b10, IB = 2'b11} block_mode_t;
endpackage

// File: rtl/arm_block_transfer_seq_scanner.sv
// arm_block_transfer_seq_scanner: lowest set bit index and popcount of a register list.
module arm_block_transfer_seq_scanner #(
  parameter int N = 16,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  i_list,
  output logic [IW-1:0] o_low,
  output logic [CW-1:0] o_cnt
);
  always_comb begin
    o_low = '0;
    o_cnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_list[i]) o_low = IW'(i);
      o_cnt = o_cnt + CW'(i_list[i]);
    end
  end
endmodule

// File: rtl/arm_block_transfer_seq.sv
// arm_block_transfer_seq: sequences ARM LDM/STM word transfers, base writeback and S-bit rules.
module arm_block_transfer_seq
  import arm_block_transfer_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_REGS = 16,
  localparam int IW = $clog2(NUM_REGS),
  localparam int CW = $clog2(NUM_REGS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  output logic                o_start_ready,
  input  logic                i_is_load,
  input  logic                i_p,
  input  logic                i_u,
  input  logic                i_s,
  input  logic                i_w,
  input  logic [NUM_REGS-1:0] i_reg_list,
  input  logic [IW-1:0]       i_rn_idx,
  input  logic [ADDR_W-1:0]   i_base_val,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [ADDR_W-1:0]   o_mem_wdata,
  input  logic                i_mem_ack,
  input  logic [ADDR_W-1:0]   i_mem_rdata,
  output logic [IW-1:0]       o_rf_rd_idx,
  input  logic [ADDR_W-1:0]   i_rf_rd_data,
  output logic                o_rf_wr_en,
  output logic [IW-1:0]       o_rf_wr_idx,
  output logic [ADDR_W-1:0]   o_rf_wr_data,
  output logic                o_rf_user_bank,
  output logic                o_spsr_restore,
  output logic                o_done
);
  localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_XFER = 3'd2, S_WB = 3'd3;
  logic [2:0]          r_state;
  logic [NUM_REGS-1:0] r_list;
  logic [ADDR_W-1:0]   r_base, r_addr, r_new_base;
  logic [IW-1:0]       r_rn;
  logic                r_is_load, r_s, r_w, r_empty, r_r15, r_rn_in, r_rn_lowest;
  block_mode_t         r_mode;
  logic [IW-1:0]       w_low;
  logic [CW-1:0]       w_cnt;
  logic [NUM_REGS-1:0] w_in_list;
  logic [ADDR_W-1:0]   w_base, w_span, w_start;
  logic                w_xfer, w_wb, w_ld_wr, w_wb_en, w_store_rn;

  arm_block_transfer_seq_scanner #(.N(NUM_REGS)) u_scan (
    .i_list(r_list),
    .o_low (w_low),
    .o_cnt (w_cnt)
  );

  // An empty list behaves as {R15} but moves the base by the full 16 words.
  assign w_in_list = i_reg_list == '0 ? {1'b1, {(NUM_REGS-1){1'b0}}} : i_reg_list;
  assign w_base    = {r_base[ADDR_W-1:2], 2'b00};
  assign w_span    = (r_empty ? ADDR_W'(NUM_REGS) : ADDR_W'(w_cnt)) * ADDR_W'(WORD_BYTES);
  assign w_start   = r_mode == IA ? w_base :
                     r_mode == IB ? w_base + ADDR_W'(WORD_BYTES) :
                     r_mode == DA ? w_base - w_span + ADDR_W'(WORD_BYTES) : w_base - w_span;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_list      <= '0;
      r_base      <= '0;
      r_addr      <= '0;
      r_new_base  <= '0;
      r_rn        <= '0;
      r_is_load   <= 1'b0;
      r_s         <= 1'b0;
      r_w         <= 1'b0;
      r_empty     <= 1'b0;
      r_r15       <= 1'b0;
      r_rn_in     <= 1'b0;
      r_rn_lowest <= 1'b0;
      r_mode      <= IA;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state   <= S_SETUP;
          r_list    <= w_in_list;
          r_empty   <= i_reg_list == '0;
          r_base    <= i_base_val;
          r_rn      <= i_rn_idx;
          r_is_load <= i_is_load;
          r_s       <= i_s;
          r_w       <= i_w;
          r_mode    <= block_mode_t'({i_p, i_u});
          r_r15     <= w_in_list[NUM_REGS-1];
          r_rn_in   <= w_in_list[i_rn_idx];
        end
        S_SETUP: begin
          r_state     <= S_XFER;
          r_addr      <= w_start;
          r_new_base  <= r_mode inside {IA, IB} ? w_base + w_span : w_base - w_span;
          r_rn_lowest <= w_low == r_rn;
        end
        S_XFER: if (i_mem_ack) begin
          r_list  <= r_list & ~(NUM_REGS'(1) << w_low);
          r_addr  <= r_addr + ADDR_W'(WORD_BYTES);
          r_state <= w_cnt == CW'(1) ? S_WB : S_XFER;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_xfer         = r_state == S_XFER;
  assign w_wb           = r_state == S_WB;
  assign w_ld_wr        = w_xfer && r_is_load && i_mem_ack;
  // A loaded Rn takes precedence over the written-back base.
  assign w_wb_en        = w_wb && r_w && !(r_is_load && r_rn_in);
  assign w_store_rn     = r_w && w_low == r_rn;
  assign o_start_ready  = r_state == S_IDLE;
  assign o_mem_req      = w_xfer;
  assign o_mem_we       = w_xfer && !r_is_load;
  assign o_mem_addr     = w_xfer ? r_addr : '0;
  assign o_mem_wdata    = !o_mem_we ? '0 : w_store_rn ? (r_rn_lowest ? r_base : r_new_base) : i_rf_rd_data;
  assign o_rf_rd_idx    = w_xfer ? w_low : '0;
  assign o_rf_wr_en     = w_ld_wr || w_wb_en;
  assign o_rf_wr_idx    = w_ld_wr ? w_low : w_wb_en ? r_rn : '0;
  assign o_rf_wr_data   = w_ld_wr ? i_mem_rdata : w_wb_en ? r_new_base : '0;
  assign o_rf_user_bank = w_xfer && r_s && !(r_is_load && r_r15);
  assign o_spsr_restore = w_wb && r_s && r_is_load && r_r15;
  assign o_done         = w_wb;
endmodule

// File: tb/tb_arm_block_transfer_seq.sv
// tb_arm_block_transfer_seq: directed and randomized checks of the LDM/STM sequencer.
module tb_arm_block_transfer_seq;
  typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata;} mx_t;
  typedef struct packed {logic [3:0] idx; logic [31:0] data;} rw_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, is_load = 1'b0, p_f = 1'b0, u_f = 1'b0, s_f = 1'b0, w_f = 1'b0;
  logic [15:0] reg_list = '0;
  logic [3:0]  rn_idx = '0;
  logic [31:0] base_val = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        start_ready, mem_req, mem_we, rf_wr_en, rf_user_bank, spsr_restore, done;
  logic [31:0] mem_addr, mem_wdata, rf_rd_data, rf_wr_data;
  logic [3:0]  rf_rd_idx, rf_wr_idx;
  logic [31:0] rf [16];
  logic [31:0] rf_seed [16];
  logic        rf_init = 1'b0;
  logic [31:0] salt = '0;
  mx_t obs_m[$], exp_m[$];
  rw_t obs_r[$], exp_r[$];
  int done_t, spsr_cnt, spsr_at_done, ub_cyc, req_cyc, unstable;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  arm_block_transfer_seq dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .o_start_ready(start_ready),
    .i_is_load(is_load), .i_p(p_f), .i_u(u_f), .i_s(s_f), .i_w(w_f),
    .i_reg_list(reg_list), .i_rn_idx(rn_idx), .i_base_val(base_val),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_rf_rd_idx(rf_rd_idx), .i_rf_rd_data(rf_rd_data),
    .o_rf_wr_en(rf_wr_en), .o_rf_wr_idx(rf_wr_idx), .o_rf_wr_data(rf_wr_data),
    .o_rf_user_bank(rf_user_bank), .o_spsr_restore(spsr_restore), .o_done(done)
  );

  // Register-file model: combinational read, posedge write, bulk preload from rf_seed.
  assign rf_rd_data = rf[rf_rd_idx];
  always @(posedge clk) begin
    if (rf_init) for (int i = 0; i < 16; i++) rf[i] <= rf_seed[i];
    else if (rf_wr_en) rf[rf_wr_idx] <= rf_wr_data;
  end

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ salt ^ 32'h5A5A_0000;
  endfunction

  task automatic load_rf();
    @(negedge clk);
    rf_init = 1'b1;
    @(negedge clk);
    rf_init = 1'b0;
  endtask

  // Drives one instruction and records what the DUT does; t counts cycles after start is sampled.
  task automatic run_op(input logic ld, p, u, s, w, input logic [15:0] rl, input logic [3:0] rn,
                        input logic [31:0] base, input int dly);
    int  wc;
    bit  fin;
    mx_t hold;
    obs_m.delete(); obs_r.delete();
    done_t = -1; spsr_cnt = 0; spsr_at_done = 0; ub_cyc = 0; req_cyc = 0; unstable = 0;
    wc = 0; fin = 0; hold = '0;
    @(negedge clk);
    start = 1'b1; is_load = ld; p_f = p; u_f = u; s_f = s; w_f = w;
    reg_list = rl; rn_idx = rn; base_val = base;
    for (int t = 1; t < 400 && !fin; t++) begin
      @(negedge clk);
      start = 1'b0;
      mem_ack = 1'b0;
      if (mem_req) begin
        req_cyc++;
        if (wc > 0 && {mem_addr, mem_we, mem_wdata} !== hold) unstable++;
        hold = {mem_addr, mem_we, mem_wdata};
        if (wc < dly) wc++;
        else begin
          mem_ack = 1'b1;
          mem_rdata = rd(mem_addr);
          obs_m.push_back(hold);
          wc = 0;
        end
      end
      #1;
      if (rf_wr_en) obs_r.push_back({rf_wr_idx, rf_wr_data});
      if (rf_user_bank) ub_cyc++;
      if (spsr_restore) begin spsr_cnt++; spsr_at_done += int'(done); end
      if (done) begin done_t = t; fin = 1; end
    end
    mem_ack = 1'b0;
    if (!fin) begin
      compared++; mismatched++;
      $display("FAIL timeout: done never seen within 400 cycles, required a done pulse");
    end
  endtask

  // Reference: expected transfers and register writes, straight from the LDM/STM rules.
  task automatic model(input logic ld, p, u, w, input logic [15:0] rl, input logic [3:0] rn,
                       input logic [31:0] base);
    logic [15:0] l;
    logic [31:0] b, nb, a, d;
    int n;
    bit first;
    exp_m.delete(); exp_r.delete();
    l = rl == 0 ? 16'h8000 : rl;
    n = rl == 0 ? 16 : $countones(rl);
    b = base & ~32'h3;
    nb = u ? b + 32'(4 * n) : b - 32'(4 * n);
    a = u ? (p ? b + 4 : b) : (p ? b - 32'(4 * n) : b - 32'(4 * n) + 4);
    first = 1;
    for (int r = 0; r < 16; r++) if (l[r]) begin
      d = ld ? 32'h0 : (w && r == int'(rn)) ? (first ? base : nb) : rf_seed[r];
      exp_m.push_back(mx_t'{a, !ld, d});
      if (ld) exp_r.push_back(rw_t'{4'(r), rd(a)});
      a += 4;
      first = 0;
    end
    if (w && !(ld && l[rn])) exp_r.push_back(rw_t'{rn, nb});
  endtask

  task automatic test_reset();
    logic [110:0] o;
    #2;
    o = {start_ready, mem_req, mem_we, mem_addr, mem_wdata, rf_rd_idx, rf_wr_en, rf_wr_idx,
         rf_wr_data, rf_user_bank, spsr_restore, done};
    compared++;
    if (o !== {1'b1, 110'd0}) begin mismatched++; $display("FAIL reset_outputs: got %h want %h", o, {1'b1, 110'd0}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if ({start_ready, mem_req, done} !== 3'b100) begin
      mismatched++; $display("FAIL reset_release: got %b want 100", {start_ready, mem_req, done});
    end
  endtask

  task automatic test_ldmia();
    foreach (rf_seed[i]) rf_seed[i] = $urandom;
    load_rf(); salt = $urandom;
    exp_m.delete(); exp_r.delete();
    for (int i = 0; i < 3; i++) begin
      exp_m.push_back(mx_t'{32'h100 + 32'(4 * i), 1'b0, 32'h0});
      exp_r.push_back(rw_t'{4'(i + 1), rd(32'h100 + 32'(4 * i))});
    end
    exp_r.push_back(rw_t'{4'd0, 32'h10C});
    run_op(1, 0, 1, 0, 1, 16'h000E, 4'd0, 32'h100, 0);
    compared++;
    if (obs_m.size() != 3 || obs_r.size() != 4) begin
      mismatched++; $display("FAIL ldmia_count: got %0d/%0d want 3/4", obs_m.size(), obs_r.size());
    end
    foreach (exp_m[i]) if (i < obs_m.size()) begin
      compared++;
      if (obs_m[i] !== exp_m[i]) begin mismatched++; $display("FAIL ldmia_mem[%0d]: got %h want %h", i, obs_m[i], exp_m[i]); end
    end
    foreach (exp_r[i]) if (i < obs_r.size()) begin
      compared++;
      if (obs_r[i] !== exp_r[i]) begin mismatched++; $display("FAIL ldmia_rf[%0d]: got %h want %h", i, obs_r[i], exp_r[i]); end
    end
    compared++;
    if (done_t != 5) begin mismatched++; $display("FAIL ldmia_latency: got %0d want 5", done_t); end
  endtask

  task automatic test_stmdb();
    foreach (rf_seed[i]) rf_seed[i] = $urandom;
    load_rf();
    run_op(0, 1, 0, 0, 1, 16'h4010, 4'd0, 32'h3000_0200, 0);
    compared++;
    if (obs_m.size() != 2 || obs_r.size() != 1) begin
      mismatched++; $display("FAIL stmdb_count: got %0d/%0d want 2/1", obs_m.size(), obs_r.size());
    end else begin
      compared += 3;
      if (obs_m[0] !== mx_t'{32'h3000_01F8, 1'b1, rf_seed[4]}) begin
        mismatched++; $display("FAIL stmdb_mem0: got %h want %h", obs_m[0], mx_t'{32'h3000_01F8, 1'b1, rf_seed[4]});
      end
      if (obs_m[1] !== mx_t'{32'h3000_01FC, 1'b1, rf_seed[14]}) begin
        mismatched++; $display("FAIL stmdb_mem1: got %h want %h", obs_m[1], mx_t'{32'h3000_01FC, 1'b1, rf_seed[14]});
      end
      if (obs_r[0] !== rw_t'{4'd0, 32'h3000_01F8}) begin
        mismatched++; $display("FAIL stmdb_wb: got %h want %h", obs_r[0], rw_t'{4'd0, 32'h3000_01F8});
      end
    end
  endtask

  task automatic test_empty_list();
    foreach (rf_seed[i]) rf_seed[i] = $urandom;
    load_rf(); salt = $urandom;
    run_op(1, 0, 1, 0, 1, 16'h0000, 4'd0, 32'h200, 0);
    compared++;
    if (obs_m.size() != 1 || obs_r.size() != 2) begin
      mismatched++; $display("FAIL empty_count: got %0d/%0d want 1/2", obs_m.size(), obs_r.size());
    end else begin
      compared += 3;
      if (obs_m[0] !== mx_t'{32'h200, 1'b0, 32'h0}) begin
        mismatched++; $display("FAIL empty_mem: got %h want %h", obs_m[0], mx_t'{32'h200, 1'b0, 32'h0});
      end
      if (obs_r[0] !== rw_t'{4'd15, rd(32'h200)}) begin
        mismatched++; $display("FAIL empty_r15: got %h want %h", obs_r[0], rw_t'{4'd15, rd(32'h200)});
      end
      if (obs_r[1] !== rw_t'{4'd0, 32'h240}) begin
        mismatched++; $display("FAIL empty_wb: got %h want %h", obs_r[1], rw_t'{4'd0, 32'h240});
      end
    end
    compared++;
    if (done_t != 3) begin mismatched++; $display("FAIL empty_latency: got %0d want 3", done_t); end
  endtask

  task automatic test_stm_rn_in_list();
    foreach (rf_seed[i]) rf_seed[i] = $urandom;
    rf_seed[2] = 32'h1000;
    load_rf();
    run_op(0, 0, 1, 0, 1, 16'h0006, 4'd2, 32'h1000, 0);
    compared++;
    if (obs_m.size() != 2 || obs_r.size() != 1) begin
      mismatched++; $display("FAIL stm_rn_count: got %0d/%0d want 2/1", obs_m.size(), obs_r.size());
    end else begin
      compared += 3;
      if (obs_m[0] !== mx_t'{32'h1000, 1'b1, rf_seed[1]}) begin
        mismatched++; $display("FAIL stm_rn_r1: got %h want %h", obs_m[0], mx_t'{32'h1000, 1'b1, rf_seed[1]});
      end
      if (obs_m[1] !== mx_t'{32'h1004, 1'b1, 32'h1008}) begin
        mismatched++; $display("FAIL stm_rn_newbase: got %h want %h", obs_m[1], mx_t'{32'h1004, 1'b1, 32'h1008});
      end
      if (obs_r[0] !== rw_t'{4'd2, 32'h1008}) begin
        mismatched++; $display("FAIL stm_rn_wb: got %h want %h", obs_r[0], rw_t'{4'd2, 32'h1008});
      end
    end
    load_rf();
    run_op(0, 0, 1, 0, 1, 16'h0004, 4'd2, 32'h1000, 0);
    compared++;
    if (obs_m.size() != 1 || obs_r.size() != 1) begin
      mismatched++; $display("FAIL stm_rn_low_count: got %0d/%0d want 1/1", obs_m.size(), obs_r.size());
    end else begin
      compared += 2;
      if (obs_m[0] !== mx_t'{32'h1000, 1'b1, 32'h1000}) begin
        mismatched++; $display("FAIL stm_rn_orig: got %h want %h", obs_m[0], mx_t'{32'h1000, 1'b1, 32'h1000});
      end
      if (obs_r[0] !== rw_t'{4'd2, 32'h1004}) begin
        mismatched++; $display("FAIL stm_rn_low_wb: got %h want %h", obs_r[0], rw_t'{4'd2, 32'h1004});
      end
    end
  endtask

  task automatic test_ldmib_s_delayed();
    foreach (rf_seed[i]) rf_seed[i] = $urandom;
    load_rf(); salt = $urandom;
    exp_m.delete(); exp_r.delete();
    exp_m.push_back(mx_t'{32'h404, 1'b0, 32'h0});
    exp_m.push_back(mx_t'{32'h408, 1'b0, 32'h0});
    exp_m.push_back(mx_t'{32'h40C, 1'b0, 32'h0});
    exp_r.push_back(rw_t'{4'd0, rd(32'h404)});
    exp_r.push_back(rw_t'{4'd1, rd(32'h408)});
    exp_r.push_back(rw_t'{4'd15, rd(32'h40C)});
    run_op(1, 1, 1, 1, 0, 16'h8003, 4'd5, 32'h400, 3);
    compared++;
    if (obs_m.size() != 3 || obs_r.size() != 3) begin
      mismatched++; $display("FAIL ldmib_count: got %0d/%0d want 3/3", obs_m.size(), obs_r.size());
    end
    foreach (exp_m[i]) if (i < obs_m.size()) begin
      compared++;
      if (obs_m[i] !== exp_m[i]) begin mismatched++; $display("FAIL ldmib_mem[%0d]: got %h want %h", i, obs_m[i], exp_m[i]); end
    end
    foreach (exp_r[i]) if (i < obs_r.size()) begin
      compared++;
      if (obs_r[i] !== exp_r[i]) begin mismatched++; $display("FAIL ldmib_rf[%0d]: got %h want %h", i, obs_r[i], exp_r[i]); end
    end
    compared++;
    if (unstable != 0 || req_cyc != 12) begin
      mismatched++; $display("FAIL ldmib_hold: got unstable=%0d req=%0d want 0/12", unstable, req_cyc);
    end
    compared++;
    if (spsr_cnt != 1 || spsr_at_done != 1 || ub_cyc != 0) begin
      mismatched++; $display("FAIL ldmib_psr: got spsr=%0d with_done=%0d ub=%0d want 1/1/0", spsr_cnt, spsr_at_done, ub_cyc);
    end
    compared++;
    if (done_t != 14) begin mismatched++; $display("FAIL ldmib_latency: got %0d want 14", done_t); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [34:0] o;
    foreach (rf_seed[i]) rf_seed[i] = $urandom;
    rf_seed[0] = 32'hCAFE_0000;
    load_rf(); salt = $urandom;
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; p_f = 1'b0; u_f = 1'b1; s_f = 1'b0; w_f = 1'b1;
    reg_list = 16'h00F0; rn_idx = 4'd0; base_val = 32'h800;
    @(negedge clk); start = 1'b0;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = rd(mem_addr);
    @(negedge clk); mem_ack = 1'b0;
    compared++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h804}) begin
      mismatched++; $display("FAIL rstmid_second: got %b/%h want 1/00000804", mem_req, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    o = {mem_req, rf_wr_en, done, start_ready, mem_addr[30:0]};
    compared++;
    if (o !== {4'b0001, 31'd0}) begin mismatched++; $display("FAIL rstmid_outputs: got %h want %h", o, {4'b0001, 31'd0}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (rf[0] !== 32'hCAFE_0000) begin mismatched++; $display("FAIL rstmid_no_wb: got %h want cafe0000", rf[0]); end
    run_op(0, 0, 1, 0, 0, 16'h0001, 4'd3, 32'h900, 0);
    compared++;
    if (obs_m.size() != 1 || done_t != 3) begin
      mismatched++; $display("FAIL rstmid_restart: got %0d xfers done@%0d want 1 done@3", obs_m.size(), done_t);
    end
  endtask

  task automatic test_random();
    logic ld, p, u, s, w;
    logic [15:0] rl;
    logic [3:0] rn;
    logic [31:0] base;
    int dly, k, exp_spsr, exp_ub;
    for (int it = 0; it < 40; it++) begin
      ld = 1'($urandom); p = 1'($urandom); u = 1'($urandom); s = 1'($urandom); w = 1'($urandom);
      rl = ($urandom % 8 == 0) ? 16'h0 : 16'($urandom);
      rn = 4'($urandom); base = $urandom; dly = $urandom_range(0, 2);
      foreach (rf_seed[i]) rf_seed[i] = $urandom;
      load_rf(); salt = $urandom;
      model(ld, p, u, w, rl, rn, base);
      k = rl == 0 ? 1 : $countones(rl);
      exp_spsr = (s && ld && (rl == 0 || rl[15])) ? 1 : 0;
      exp_ub = (s && !exp_spsr) ? k * (dly + 1) : 0;
      run_op(ld, p, u, s, w, rl, rn, base, dly);
      compared++;
      if (obs_m.size() != exp_m.size() || obs_r.size() != exp_r.size()) begin
        mismatched++;
        $display("FAIL rand%0d_count: got %0d/%0d want %0d/%0d", it, obs_m.size(), obs_r.size(), exp_m.size(), exp_r.size());
      end
      foreach (exp_m[i]) if (i < obs_m.size()) begin
        compared++;
        if (obs_m[i] !== exp_m[i]) begin mismatched++; $display("FAIL rand%0d_mem[%0d]: got %h want %h", it, i, obs_m[i], exp_m[i]); end
      end
      foreach (exp_r[i]) if (i < obs_r.size()) begin
        compared++;
        if (obs_r[i] !== exp_r[i]) begin mismatched++; $display("FAIL rand%0d_rf[%0d]: got %h want %h", it, i, obs_r[i], exp_r[i]); end
      end
      compared++;
      if (done_t != 2 + k * (dly + 1) || spsr_cnt != exp_spsr || ub_cyc != exp_ub || unstable != 0) begin
        mismatched++;
        $display("FAIL rand%0d_ctrl: got done@%0d spsr=%0d ub=%0d unstable=%0d want done@%0d spsr=%0d ub=%0d unstable=0",
                 it, done_t, spsr_cnt, ub_cyc, unstable, 2 + k * (dly + 1), exp_spsr, exp_ub);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldmia();
    test_stmdb();
    test_empty_list();
    test_stm_rn_in_list();
    test_ldmib_s_delayed();
    test_reset_mid_transfer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
